// File: rtl/mux16_rr_scheduler_pkg.sv
// Shared types and constants for the 16-way round-robin mux scheduler.
package mux16_rr_scheduler_pkg;

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned SEL_W   = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StGap   = 2'd2
  } state_e;

endpackage

// File: rtl/mux16_rr_scheduler_pick.sv
// Combinational round-robin picker.
// Finds the first set request bit, starting one past ptr and wrapping mod 16.
module rr_pick16
  import mux16_rr_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W:0]       shamt;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     off;

  // Rotating right by ptr+1 puts the highest-priority candidate at bit 0.
  // A shift of 16 on the doubled vector returns req unrotated.
  assign shamt = {1'b0, ptr} + (SEL_W + 1)'(1);
  assign rot   = NUM_REQ'({req, req} >> shamt);

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
  end

  // Undo the rotation; 4-bit arithmetic provides the mod-16 wrap.
  assign idx = ptr + SEL_W'(1) + off;

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler driving the select of a 16:1 bit mux.
// Grants one requester at a time, samples the mux output for the owner, and
// inserts a one-cycle gap between owners so the select settles.
module mux16_rr_scheduler
  import mux16_rr_scheduler_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mux_o,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               data_q,
  output logic               data_vld
);

  localparam bit HoldLimited = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HoldLast = HoldLimited ? HOLD_W'(MAX_HOLD - 1) : '0;

  state_e              state_q;
  logic [SEL_W-1:0]    ptr_q;
  logic [HOLD_W-1:0]   hold_cnt_q;

  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;
  logic                owner_req;
  logic                hold_expired;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_req    = req[sel];
  assign hold_expired = HoldLimited && (hold_cnt_q == HoldLast);

  // Scheduler FSM with registered grant, select and sampled data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= SEL_W'(NUM_REQ - 1);
      hold_cnt_q <= '0;
      sel        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      data_q     <= 1'b0;
      data_vld   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          gnt      <= '0;
          data_vld <= 1'b0;
          if (pick_found) begin
            state_q    <= StGrant;
            sel        <= pick_idx;
            gnt        <= NUM_REQ'(1) << pick_idx;
            busy       <= 1'b1;
            ptr_q      <= pick_idx;
            hold_cnt_q <= '0;
          end
        end
        StGrant: begin
          // Owner release takes priority over sampling; data_q holds on exit.
          if (!owner_req || hold_expired) begin
            state_q  <= StGap;
            gnt      <= '0;
            data_vld <= 1'b0;
          end else begin
            data_q   <= mux_o;
            data_vld <= 1'b1;
            if (hold_cnt_q != '1) begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        StGap: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
